reg_bank_wb: RTL
================

REG_BANK_WB -- requirements
Module: reg_bank_wb

Interface
REQ-001 Parameter DW, default 32: data width of every register and data port.
REQ-002 Parameter AW, default 5: address width, giving 2**AW = 32 registers.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous and active-low.
REQ-005 we  input  1: write request qualifier, sampled at rising clk.
REQ-006 wa  input  AW: write register address, driven by the upstream write-register select mux.
REQ-007 wd  input  DW: write data.
REQ-008 ra1  input  AW: read port 1 address.
REQ-009 ra2  input  AW: read port 2 address.
REQ-010 rd1  output  DW: read port 1 data, combinational from ra1 and state.
REQ-011 rd2  output  DW: read port 2 data, combinational from ra2 and state.
REQ-012 pend_v  output  1: a sampled write is pending commit in the write-back register.
REQ-013 wr_count  output  16: count of accepted writes.

Function
REQ-014 Storage SHALL be registers 1..31 of DW bits each; register 0 SHALL read as all-zero at all times and SHALL never be stored.
REQ-015 A write SHALL be accepted at a rising edge when we=1 and wa!=0.
- On acceptance: pend_v<=1, pend_a<=wa, pend_d<=wd.
- Otherwise pend_v<=0.
REQ-016 we=1 with wa=0 SHALL be discarded: no pend_v, no count, no storage change.
REQ-017 At any rising edge with pend_v=1, the array SHALL commit array[pend_a]<=pend_d; this happens in the same edge that may capture a new request.
REQ-018 Commit latency SHALL be exactly one edge: a request sampled at edge N is written to the array at edge N+1.
REQ-019 Read priority per port, highest first:
- ra==0 -> 0.
- pend_v=1 and pend_a==ra -> pend_d.
- otherwise array[ra].
REQ-020 The current-cycle wd input SHALL NOT be forwarded to rd1 or rd2; a write becomes readable only after its sampling edge.
REQ-021 Back-to-back accepted writes to the same address SHALL leave the later data visible, both through forwarding and in the array; commits SHALL occur in request order.
REQ-022 Both read ports SHALL operate independently, including when addressing the same register.
REQ-023 wr_count SHALL increment by 1 on each accepted write and SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-024 While rst_n=0, asynchronously and independent of clk: registers 1..31 = 0, pend_v=0, pend_a=0, pend_d=0, wr_count=0, so rd1=rd2=0.
REQ-025 Reset asserted while pend_v=1 SHALL drop the pending write; it is never committed.
REQ-026 The first request SHALL be sampled at the first rising edge after rst_n deasserts.

Structure
REQ-027 Package fp_f2_pkg SHALL hold the DW and AW default constants, the REG_ZERO address constant, and the register-count constant.
REQ-028 Each read port SHALL be one instance of sub-module reg_bank_fwd, a combinational zero/forward/array priority select; reg_bank_wb SHALL instantiate it twice.

Verification
REQ-029 Reset mid-run, with all regs previously written -> rd1=rd2=0 for every ra, pend_v=0, wr_count=0.
REQ-030 we=1, wa=5, wd=0xDEADBEEF at edge N; ra1=5 -> rd1=0 before edge N, 0xDEADBEEF after edge N via forwarding (pend_v=1), and still 0xDEADBEEF after edge N+1 from the array (pend_v=0).
REQ-031 we=1, wa=0, wd=0x12345678 -> rd1 with ra1=0 stays 0, pend_v stays 0, wr_count unchanged.
REQ-032 Writes to address 7 with 0x11 at edge N and 0x22 at edge N+1 -> rd1=0x11 after edge N, 0x22 after edge N+1 onward; array[7]=0x22 after edge N+2.
REQ-033 ra1=ra2=9 with a pending write to 9 of 0xA5A5A5A5 -> rd1=rd2=0xA5A5A5A5; ra2=10 in the same cycle -> array[10].
REQ-034 wr_count preset to 0xFFFF by 65535 accepted writes, then one more accepted write -> wr_count=0x0000.

Source files
------------

// File: rtl/fp_f2_pkg.sv
// Shared constants for the write-back register bank: default widths,
// the hard-wired zero register address and the register count.
package fp_f2_pkg;
  localparam int DW_DEF   = 32;
  localparam int AW_DEF   = 5;
  localparam int REG_ZERO = 0;
  localparam int NUM_REGS = 1 << AW_DEF;
endpackage

// File: rtl/reg_bank_fwd.sv
// One read port: zero register, then the pending write-back, then the array.
// Purely combinational, no backpressure.
module reg_bank_fwd
  import fp_f2_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic [AW-1:0] ra,
  input  logic          pend_v,
  input  logic [AW-1:0] pend_a,
  input  logic [DW-1:0] pend_d,
  input  logic [DW-1:0] arr_d,
  output logic [DW-1:0] rd
);

  always_comb begin
    rd = arr_d;
    if (ra == AW'(REG_ZERO)) begin
      rd = '0;
    end else if (pend_v && (pend_a == ra)) begin
      rd = pend_d;
    end
  end

endmodule

// File: rtl/reg_bank_wb.sv
// Register bank with a one-entry write-back stage: writes commit one edge after
// sampling, are forwarded to both read ports meanwhile; writes are never stalled.
module reg_bank_wb
  import fp_f2_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic          pend_v,
  output logic [15:0]   wr_count
);

  localparam int NREGS = 1 << AW;

  // Register 0 has no storage; the read muxes supply its zero value.
  logic [DW-1:0] regs [1:NREGS-1];
  logic [AW-1:0] pend_a;
  logic [DW-1:0] pend_d;
  logic          accept;
  logic [DW-1:0] arr_d1;
  logic [DW-1:0] arr_d2;

  assign accept = we && (wa != AW'(REG_ZERO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v   <= 1'b0;
      pend_a   <= '0;
      pend_d   <= '0;
      wr_count <= '0;
    end else begin
      pend_v <= accept;
      if (accept) begin
        pend_a   <= wa;
        pend_d   <= wd;
        wr_count <= wr_count + 16'd1;
      end
    end
  end

  // Commit of the previous request shares the edge with capture of the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (pend_v) begin
      regs[pend_a] <= pend_d;
    end
  end

  // Address 0 selects outside the array; the port mux discards that value.
  assign arr_d1 = regs[ra1];
  assign arr_d2 = regs[ra2];

  reg_bank_fwd #(.DW(DW), .AW(AW)) u_fwd1 (
    .ra     (ra1),
    .pend_v (pend_v),
    .pend_a (pend_a),
    .pend_d (pend_d),
    .arr_d  (arr_d1),
    .rd     (rd1)
  );

  reg_bank_fwd #(.DW(DW), .AW(AW)) u_fwd2 (
    .ra     (ra2),
    .pend_v (pend_v),
    .pend_a (pend_a),
    .pend_d (pend_d),
    .arr_d  (arr_d2),
    .rd     (rd2)
  );

endmodule
